// File: rtl/piso_register_tx_if.sv
// Load handshake and serial output bundle for the parallel-in/serial-out transmitter.
// The master drives words and the bit tick; the slave (transmitter) drives the serial side.
interface piso_register_tx_if #(
   parameter int WIDTH = 7
) ();
   logic             en;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] d;
   logic             sdo;
   logic             sdo_valid;
   logic             busy;
   logic             done;

   modport master (
      output en, load_valid, d,
      input  load_ready, sdo, sdo_valid, busy, done
   );

   modport slave (
      input  en, load_valid, d,
      output load_ready, sdo, sdo_valid, busy, done
   );
endinterface

// File: rtl/piso_register_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on a valid/ready handshake
// and shifts it out one bit per enabled edge, pulsing done once the last bit has been shown.
module piso_register_tx #(
   parameter int WIDTH     = 7,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic               clk,
   input logic               reset,
   piso_register_tx_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] shift_nxt_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sdo_q, sdo_d;
   logic             sdo_valid_q, sdo_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load_ready_q, load_ready_d;

   // Next state, shift register and bit counter
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (MSB_FIRST) begin
         shift_nxt_s = {shift_q[WIDTH-2:0], 1'b0};
      end else begin
         shift_nxt_s = {1'b0, shift_q[WIDTH-1:1]};
      end
      case (state_q)
         ST_IDLE: begin
            // load_ready_q is high exactly while idle, so this is the handshake itself
            if (bus.load_valid && load_ready_q) begin
               shift_d = bus.d;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (bus.en) begin
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_DONE;
                  shift_d = '0;
               end else begin
                  shift_d = shift_nxt_s;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            shift_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode from the upcoming state so every output leaves a flop
   always_comb begin
      sdo_d        = 1'b0;
      sdo_valid_d  = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      load_ready_d = 1'b0;
      case (state_d)
         ST_IDLE: begin
            load_ready_d = 1'b1;
         end
         ST_SHIFT: begin
            busy_d      = 1'b1;
            sdo_valid_d = 1'b1;
            if (MSB_FIRST) begin
               sdo_d = shift_d[WIDTH-1];
            end else begin
               sdo_d = shift_d[0];
            end
         end
         ST_DONE: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         default: begin
            load_ready_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any transfer in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         cnt_q        <= '0;
         sdo_q        <= 1'b0;
         sdo_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         sdo_q        <= sdo_d;
         sdo_valid_q  <= sdo_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         load_ready_q <= load_ready_d;
      end
   end

   assign bus.sdo        = sdo_q;
   assign bus.sdo_valid  = sdo_valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.load_ready = load_ready_q;
endmodule

// File: tb/tb_piso_register_tx.sv
// Randomised and directed bench for piso_register_tx, run on an MSB-first and an LSB-first
// instance side by side against a bit-queue model of the transfer.
module tb_piso_register_tx;
   localparam int W = 7;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         en = 1'b1;
   logic         lv = 1'b0;
   logic [W-1:0] d = '0;

   int n_chk = 0;
   int n_fail = 0;

   bit qm[$];
   bit ql[$];
   bit done_p = 1'b0;
   bit log_m[$];
   int done_cnt = 0;
   int valid_cnt = 0;

   piso_register_tx_if #(.WIDTH(W)) if_m ();
   piso_register_tx_if #(.WIDTH(W)) if_l ();

   assign if_m.en = en;
   assign if_m.load_valid = lv;
   assign if_m.d = d;
   assign if_l.en = en;
   assign if_l.load_valid = lv;
   assign if_l.d = d;

   piso_register_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(if_m.slave));
   piso_register_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(if_l.slave));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a word becomes a queue of bits in transmit order
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         qm.delete();
         ql.delete();
         done_p = 1'b0;
      end else if (done_p) begin
         done_p = 1'b0;
      end else if (qm.size() != 0) begin
         if (en) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
            if (qm.size() == 0) done_p = 1'b1;
         end
      end else if (lv) begin
         for (int i = 0; i < W; i++) begin
            qm.push_back(d[W-1-i]);
            ql.push_back(d[i]);
         end
      end
   end

   // Per-cycle comparison of both instances against the model
   always @(posedge clk) begin
      bit ev;
      bit eb;
      bit ei;
      #3;
      ev = (qm.size() != 0);
      eb = ev || done_p;
      ei = !eb;
      chk("m_sdo_valid", 32'(if_m.sdo_valid), 32'(ev));
      chk("m_sdo", 32'(if_m.sdo), ev ? 32'(qm[0]) : 32'd0);
      chk("m_busy", 32'(if_m.busy), 32'(eb));
      chk("m_done", 32'(if_m.done), 32'(done_p));
      chk("m_load_ready", 32'(if_m.load_ready), 32'(ei));
      chk("l_sdo_valid", 32'(if_l.sdo_valid), 32'(ev));
      chk("l_sdo", 32'(if_l.sdo), ev ? 32'(ql[0]) : 32'd0);
      chk("l_busy", 32'(if_l.busy), 32'(eb));
      chk("l_done", 32'(if_l.done), 32'(done_p));
      chk("l_load_ready", 32'(if_l.load_ready), 32'(ei));
      if (if_m.sdo_valid) begin
         log_m.push_back(if_m.sdo);
         valid_cnt++;
      end
      if (if_m.done) done_cnt++;
   end

   // Single-pulse load with en high; checks the serial pattern and done/ready timing
   task automatic send_check(input logic [W-1:0] w, input logic [W-1:0] exp_m, input logic [W-1:0] exp_l);
      logic [W-1:0] got_m;
      logic [W-1:0] got_l;
      @(negedge clk);
      en = 1'b1;
      lv = 1'b1;
      d  = w;
      @(negedge clk);
      lv = 1'b0;
      for (int k = 0; k < W; k++) begin
         got_m[W-1-k] = if_m.sdo;
         got_l[W-1-k] = if_l.sdo;
         chk("lit_valid_window", 32'(if_m.sdo_valid & if_l.sdo_valid), 32'd1);
         @(negedge clk);
      end
      chk("lit_done_cycle8", 32'(if_m.done & if_l.done), 32'd1);
      @(negedge clk);
      chk("lit_ready_cycle9", 32'(if_m.load_ready & if_l.load_ready), 32'd1);
      chk("lit_stream_msb", 32'(got_m), 32'(exp_m));
      chk("lit_stream_lsb", 32'(got_l), 32'(exp_l));
   endtask

   initial begin
      logic [13:0] seq;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 1: mid-transfer reset with load_valid high
      lv = 1'b1;
      d  = 7'h3C;
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_sdo", 32'(if_m.sdo), 32'd0);
      chk("rst_sdo_valid", 32'(if_m.sdo_valid), 32'd0);
      chk("rst_busy", 32'(if_m.busy), 32'd0);
      chk("rst_done", 32'(if_m.done), 32'd0);
      chk("rst_load_ready", 32'(if_m.load_ready), 32'd1);
      repeat (3) @(negedge clk);
      chk("rst_no_load", 32'(if_m.sdo_valid | if_l.sdo_valid), 32'd0);
      lv = 1'b0;
      reset = 1'b0;
      @(negedge clk);

      // 2 and 3: same word on both bit orders
      send_check(7'b1011001, 7'b1011001, 7'b1001101);

      // 4: en alternating during SHIFT
      valid_cnt = 0;
      done_cnt = 0;
      lv = 1'b1;
      d  = 7'b1110000;
      @(negedge clk);
      lv = 1'b0;
      for (int c = 0; c < 20; c++) begin
         en = c[0];
         @(negedge clk);
      end
      en = 1'b1;
      repeat (2) @(negedge clk);
      chk("lit_en_toggle_valid", 32'(valid_cnt), 32'd14);
      chk("lit_en_toggle_done", 32'(done_cnt), 32'd1);

      // 5: load_valid held through a transfer while d changes
      log_m.delete();
      lv = 1'b1;
      d  = 7'h2A;
      @(negedge clk);
      repeat (2) @(negedge clk);
      d = 7'h55;
      repeat (7) @(negedge clk);
      lv = 1'b0;
      repeat (12) @(negedge clk);
      chk("lit_hold_count", 32'(log_m.size()), 32'd14);
      seq = '0;
      if (log_m.size() == 14) begin
         for (int i = 0; i < 14; i++) seq[13-i] = log_m[i];
      end
      chk("lit_hold_stream", 32'(seq), 32'(14'b0101010_1010101));

      // 6: reset after the third bit of 7F, then a clean transfer
      done_cnt = 0;
      lv = 1'b1;
      d  = 7'h7F;
      @(negedge clk);
      lv = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rst6_sdo_valid", 32'(if_m.sdo_valid), 32'd0);
      chk("rst6_busy", 32'(if_m.busy | if_l.busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst6_no_done", 32'(done_cnt), 32'd0);
      send_check(7'h01, 7'b0000001, 7'b1000000);

      // Random traffic with occasional reset
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         lv = ($urandom_range(0, 3) == 0);
         d  = W'($urandom);
         en = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 63) == 0);
      end
      @(negedge clk);
      reset = 1'b0;
      lv = 1'b0;
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
